// File: rtl/layer_out_serializer_if.sv
// Stream bundle between an upstream layer's parallel outputs and the serial broadcast
// feeding the next layer.
interface layer_out_serializer_if #(
  parameter int NN         = 30,
  parameter int DATA_WIDTH = 16
);
  logic [NN-1:0]            in_valid;
  logic [NN*DATA_WIDTH-1:0] in_data;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_data, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_data, out_valid, out_last
  );
endinterface

// File: rtl/layer_out_serializer.sv
// Double-buffered parallel-to-serial converter. Each lane is collected into hold[] and
// the full frame is copied to buf[], then shifted out one lane per cycle.
module layer_out_serializer #(
  parameter int NN         = 30,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  layer_out_serializer_if.slave bus,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  clr_overrun
);
  localparam int IW = $clog2(NN);
  localparam logic [IW-1:0] IDX_LAST = IW'(NN - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NN-1:0]         mask_q, mask_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] hold_q [NN];
  logic [DATA_WIDTH-1:0] hold_d [NN];
  logic [DATA_WIDTH-1:0] buf_q  [NN];
  logic [DATA_WIDTH-1:0] buf_d  [NN];

  logic hs, last_hs, xfer, ovr_event;

  always_comb begin
    hs        = (state_q == SEND) && bus.out_ready;
    last_hs   = hs && (idx_q == IDX_LAST);
    xfer      = (&mask_q) && ((state_q == IDLE) || last_hs);
    // A full mask is entirely drained by a transfer, so a repeat lane then starts the next frame.
    ovr_event = !xfer && (|(bus.in_valid & mask_q));

    mask_d = (xfer ? '0 : mask_q) | bus.in_valid;
    hold_d = hold_q;
    for (int unsigned i = 0; i < NN; i++) begin
      if (bus.in_valid[i]) hold_d[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    buf_d = xfer ? hold_q : buf_q;

    if (ovr_event)        overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
    else                  overrun_d = overrun_q;

    state_d = state_q;
    idx_d   = idx_q;
    if (xfer) begin
      state_d = SEND;
      idx_d   = '0;
    end else if (last_hs) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (hs) begin
      idx_d = idx_q + IW'(1);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
      hold_q    <= '{default: '0};
      buf_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
      hold_q    <= hold_d;
      buf_q     <= buf_d;
    end
  end

  always_comb begin
    bus.out_valid = (state_q == SEND);
    bus.out_last  = (state_q == SEND) && (idx_q == IDX_LAST);
    bus.out_data  = (state_q == SEND) ? buf_q[idx_q] : '0;
    busy          = (state_q == SEND) || (|mask_q);
    overrun       = overrun_q;
  end
endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer (NN=4): expected elements are queued as
// lanes are driven and checked on every output handshake.
module tb_layer_out_serializer;
  localparam int NN = 4;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic busy;
  logic overrun;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  layer_out_serializer_if #(.NN(NN), .DATA_WIDTH(DW)) bus ();

  layer_out_serializer #(.NN(NN), .DATA_WIDTH(DW)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .bus           (bus.slave),
    .busy          (busy),
    .overrun       (overrun),
    .clr_overrun   (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [DW-1:0] v);
    bus.in_valid[i]          = 1'b1;
    bus.in_data[i*DW +: DW] = v;
  endtask

  task automatic push_frame(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                            input logic [DW-1:0] v2, input logic [DW-1:0] v3);
    sb.push_back('{d: v0, l: 1'b0});
    sb.push_back('{d: v1, l: 1'b0});
    sb.push_back('{d: v2, l: 1'b0});
    sb.push_back('{d: v3, l: 1'b1});
  endtask

  // Checks the element that the coming edge consumes, then advances one cycle.
  task automatic tick();
    exp_t e;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {16'h0, bus.out_data}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("out_data", {16'h0, bus.out_data}, {16'h0, e.d});
        chk("out_last", {31'h0, bus.out_last}, {31'h0, e.l});
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = '0;
  endtask

  initial begin
    logic [DW-1:0] bp [NN];
    int            bp_ready [7];
    int            k;

    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_valid",   {31'h0, bus.out_valid}, 32'h0);
    chk("rst_last",    {31'h0, bus.out_last},  32'h0);
    chk("rst_busy",    {31'h0, busy},          32'h0);
    chk("rst_overrun", {31'h0, overrun},       32'h0);
    chk("rst_data",    {16'h0, bus.out_data},  32'h0);
    rst_n = 1'b1;
    tick();

    // Single frame
    bus.out_ready = 1'b1;
    set_lane(0, 16'h0001); set_lane(1, 16'h0002); set_lane(2, 16'h0003); set_lane(3, 16'h0004);
    push_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    tick();
    chk("single_lat_E", {31'h0, bus.out_valid}, 32'h0);
    chk("single_busy",  {31'h0, busy},          32'h1);
    tick();
    chk("single_lat_E1", {31'h0, bus.out_valid}, 32'h1);
    for (int i = 0; i < NN; i++) tick();
    chk("single_idle",  {31'h0, bus.out_valid}, 32'h0);
    chk("single_nbusy", {31'h0, busy},          32'h0);
    chk("single_drain", sb.size(),              32'h0);

    // Staggered lanes
    set_lane(2, 16'h1234); tick();
    tick(); tick();
    set_lane(0, 16'hA5A5); set_lane(3, 16'hFFFF); tick();
    tick();
    set_lane(1, 16'h8000);
    push_frame(16'hA5A5, 16'h8000, 16'h1234, 16'hFFFF);
    tick();
    chk("stag_lat_E5", {31'h0, bus.out_valid}, 32'h0);
    tick();
    chk("stag_lat_E6", {31'h0, bus.out_valid}, 32'h1);
    for (int i = 0; i < NN; i++) tick();
    chk("stag_overrun", {31'h0, overrun}, 32'h0);
    chk("stag_drain",   sb.size(),        32'h0);

    // Backpressure: ready pattern 1,0,0,1,1,0,1
    bp = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    bp_ready = '{1, 0, 0, 1, 1, 0, 1};
    for (int i = 0; i < NN; i++) set_lane(i, bp[i]);
    push_frame(bp[0], bp[1], bp[2], bp[3]);
    tick(); tick();
    k = 0;
    for (int i = 0; i < 7; i++) begin
      bus.out_ready = (bp_ready[i] != 0);
      tick();
      if (bp_ready[i] != 0) k++;
      if (k < NN) chk("bp_hold", {16'h0, bus.out_data}, {16'h0, bp[k]});
      else        chk("bp_done", {31'h0, bus.out_valid}, 32'h0);
    end
    chk("bp_drain", sb.size(), 32'h0);
    bus.out_ready = 1'b1;

    // Back-to-back frames
    for (int i = 0; i < NN; i++) set_lane(i, 16'h0100 + 16'(i));
    push_frame(16'h0100, 16'h0101, 16'h0102, 16'h0103);
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        for (int j = 0; j < NN; j++) set_lane(j, 16'h0200 + 16'(j));
        push_frame(16'h0200, 16'h0201, 16'h0202, 16'h0203);
      end
      tick();
      chk("b2b_valid", {31'h0, bus.out_valid}, (i < 7) ? 32'h1 : 32'h0);
    end
    chk("b2b_drain", sb.size(), 32'h0);

    // Overrun, sticky flag and clear
    set_lane(1, 16'h00AA); tick();
    chk("ovr_first", {31'h0, overrun}, 32'h0);
    set_lane(1, 16'h00BB); tick();
    chk("ovr_set", {31'h0, overrun}, 32'h1);
    set_lane(0, 16'h0C00); set_lane(2, 16'h0C02); set_lane(3, 16'h0C03);
    push_frame(16'h0C00, 16'h00BB, 16'h0C02, 16'h0C03);
    tick(); tick();
    for (int i = 0; i < NN; i++) tick();
    chk("ovr_sticky", {31'h0, overrun}, 32'h1);
    chk("ovr_drain",  sb.size(),        32'h0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ovr_clear", {31'h0, overrun}, 32'h0);

    // Clear coinciding with a new overrun event: the event wins
    set_lane(0, 16'h0D00); tick();
    set_lane(0, 16'h0D01); clr = 1'b1; tick(); clr = 1'b0;
    chk("ovr_clr_race", {31'h0, overrun}, 32'h1);

    // Reset mid-SEND at idx=2
    set_lane(1, 16'h0D11); set_lane(2, 16'h0D12); set_lane(3, 16'h0D13);
    push_frame(16'h0D01, 16'h0D11, 16'h0D12, 16'h0D13);
    tick(); tick();
    tick(); tick();
    chk("pre_rst_data", {16'h0, bus.out_data}, 32'h0D12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",   {31'h0, bus.out_valid}, 32'h0);
    chk("arst_last",    {31'h0, bus.out_last},  32'h0);
    chk("arst_busy",    {31'h0, busy},          32'h0);
    chk("arst_overrun", {31'h0, overrun},       32'h0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", {31'h0, bus.out_valid}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/layer_out_serializer.md
Name: layer_out_serializer

Overview:
- Sits between two Layer instances inside nn_top. It consumes the parallel per-neuron outputs (o_valid and x_out) of layer N.
- It emits them one neuron per cycle as the scalar data/valid stream that layer N+1 broadcasts to all of its neurons (data_out_valid_N, out_data_N).
- It is double-buffered: the next frame of layer outputs is collected while the current frame is still being shifted out.

Parameters:
- NN, 30, number of neurons in the upstream layer, i.e. lanes per frame (>=2).
- DATA_WIDTH, 16, width of one neuron output; nn_top sets this to `dataWidth.

Ports:
- s_axi_aclk  in  1  single clock; all state changes on the rising edge.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- in_valid  in  NN  per-lane valid from the upstream layer's o_valid; bit i qualifies lane i.
- in_data  in  NN*DATA_WIDTH  upstream x_out; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_data  out  DATA_WIDTH  current serial element.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts; tie to 1 in nn_top.
- out_last  out  1  high with the element from lane NN-1.
- busy  out  1  state==SEND or any collect-mask bit set.
- overrun  out  1  sticky error flag.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (async assert, sync release): state=IDLE, idx=0, mask=0, overrun=0. out_valid, out_last and busy are 0. out_data is 0. hold[] and buf[] are cleared to 0.
- Collect stage:
  - On each edge, for every lane i with in_valid[i]=1: hold[i] <= lane i data and mask[i] <= 1.
  - Lanes may arrive in any order and on different cycles.
  - If in_valid[i]=1 while mask[i] is already 1 and that mask is not being transferred this edge, overrun <= 1 and hold[i] is overwritten with the new data.
- Transfer:
  - Condition: mask is all-ones, and either state==IDLE or (state==SEND and a final handshake occurs this edge).
  - Action: buf[] <= hold[], idx <= 0, state <= SEND.
  - Mask bits are cleared, except any lane with in_valid=1 on the same edge, whose bit is set (it starts the next frame).
  - A lane valid on the transfer edge does not corrupt the transferred frame: buf takes the pre-edge hold value.
- FSM:
  - IDLE: out_valid=0. Go to SEND on transfer.
  - SEND: out_valid=1, out_data=buf[idx], out_last=(idx==NN-1).
  - On a handshake (out_valid & out_ready) with idx<NN-1: idx <= idx+1.
  - On a handshake with idx==NN-1: go to SEND via a new transfer if the mask is full, otherwise go to IDLE with idx <= 0.
  - Without out_ready, out_data and idx hold stable.
- Latency:
  - The last lane valid is sampled at edge E, so the mask is full after E.
  - Transfer happens at E+1, so out_valid=1 and lane 0 appear after E+1.
  - With out_ready=1, one element per cycle: NN cycles per frame. Back-to-back frames have no idle gap.
- Overrun:
  - clr_overrun=1 clears overrun at the edge.
  - If clr_overrun=1 coincides with a new overrun event on the same edge, the event wins and overrun=1.
- Widths:
  - idx is $clog2(NN) bits, compared exactly against NN-1. No wrap beyond NN-1.
  - Data passes through unmodified; no sign or width change.

Test Plan (NN=4, DATA_WIDTH=16):
- Reset: assert aresetn=0 mid-SEND (idx=2) -> out_valid, out_last, busy and overrun go 0 immediately; after release, out_valid stays 0 with no stimulus.
- Single frame: in_valid=4'b1111 with lanes {0x0004,0x0003,0x0002,0x0001} (lane0=0x0001) at edge E, out_ready=1 -> out_data 0x0001, 0x0002, 0x0003, 0x0004 on cycles after E+1..E+4; out_last only with 0x0004; then IDLE and busy=0.
- Staggered lanes: lane2 at E, lanes 0,3 at E+3, lane1 at E+5 -> first output after E+6; values match the lane data; overrun stays 0.
- Backpressure: out_ready toggles 1,0,0,1,1,0,1 -> each element is held while ready=0; exactly 4 handshakes in order; idx never skips.
- Back-to-back frames: frame B fully collected while frame A is on element 1 -> frame B lane 0 on the cycle immediately after A's out_last handshake; no out_valid gap.
- Overrun and clear: lane1 valid twice (0x00AA then 0x00BB) before transfer -> overrun=1; the frame emits 0x00BB for lane1; clr_overrun pulse -> overrun=0 next cycle.
